uart_wb_master: RTL and testbench

UART_WB_MASTER -- requirements
Module: uart_wb_master

---
 rtl/uart_wb_pkg.sv | 34 +++
 rtl/uart_wb_phy.sv | 189 ++++++++++++++++++
 rtl/uart_wb_master.sv | 205 ++++++++++++++++++++
 tb/tb_uart_wb_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared types and byte constants for the UART-to-Wishbone bridge.
// The optional Wishbone ack timeout is enabled with `define UART_WB_TIMEOUT_EN.
package uart_wb_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 217;

   localparam logic [7:0] CMD_WRITE   = 8'h57;
   localparam logic [7:0] CMD_READ    = 8'h52;
   localparam logic [7:0] RSP_ACK     = 8'h4B;
   localparam logic [7:0] RSP_TIMEOUT = 8'h45;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WB,
      ST_RESP
   } wb_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

endpackage

// File: rtl/uart_wb_phy.sv
// 8N1 UART receiver and transmitter with byte-level valid/ready interface.
// RX delivers one-cycle valid/error pulses; TX accepts a new byte in the last stop-bit cycle.
module uart_wb_phy
   import uart_wb_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic       tx_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_err_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_idle_o
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_valid_q, rx_valid_d;
   logic            rx_err_q, rx_err_d;

   tx_state_e       tx_state_q, tx_state_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            tx_q, tx_d;
   logic            tx_accept;

   assign rx_data_o  = rx_shift_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_err_o   = rx_err_q;
   assign tx_o       = tx_q;
   assign tx_idle_o  = (tx_state_q == TX_IDLE);
   assign tx_ready_o = (tx_state_q == TX_IDLE) ||
                       ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST));
   assign tx_accept  = tx_ready_o && tx_valid_i;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_valid_d = rx_sync_q;
               rx_err_d   = !rx_sync_q;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // The line level is driven from the next state so tx_q changes exactly on bit boundaries.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_accept) begin
               tx_state_d = TX_START;
               tx_shift_d = tx_data_i;
               tx_cnt_d   = '0;
            end
         end
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_accept) begin
                  tx_state_d = TX_START;
                  tx_shift_d = tx_data_i;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         rx_meta_q  <= rx_i;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: rtl/uart_wb_master.sv
// UART command decoder driving a classic Wishbone master; replies over the same UART.
// Define UART_WB_TIMEOUT_EN to abort unanswered bus cycles after TIMEOUT_CYCLES and reply 0x45.
module uart_wb_master
   import uart_wb_pkg::*;
#(
   parameter int BUSW           = 32,
   parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            io_wbs_clk,
   input  logic            io_wbs_rst_n,
   input  logic            uart_rx_i,
   output logic            uart_tx_o,
   output logic [BUSW-1:0] io_wbs_adr,
   output logic [BUSW-1:0] io_wbs_datwr,
   input  logic [BUSW-1:0] io_wbs_datrd,
   output logic            io_wbs_we,
   output logic            io_wbs_stb,
   output logic            io_wbs_cyc,
   input  logic            io_wbs_ack,
   output logic            busy_o
);

   logic [7:0] rx_data;
   logic       rx_valid, rx_err;
   logic       tx_valid, tx_ready, tx_idle;

   wb_state_e       state_q, state_d;
   logic [BUSW-1:0] adr_q, adr_d;
   logic [BUSW-1:0] dat_q, dat_d;
   logic            we_q, we_d;
   logic            cyc_q, cyc_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [BUSW-1:0] resp_buf_q, resp_buf_d;
   logic [2:0]      resp_cnt_q, resp_cnt_d;
   logic [2:0]      resp_len_q, resp_len_d;
   logic            busy_q, busy_d;

`ifdef UART_WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

   uart_wb_phy #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_phy (
      .clk        (io_wbs_clk),
      .rst_n      (io_wbs_rst_n),
      .rx_i       (uart_rx_i),
      .tx_o       (uart_tx_o),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .rx_err_o   (rx_err),
      .tx_data_i  (resp_buf_q[BUSW-1 -: 8]),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .tx_idle_o  (tx_idle)
   );

   assign io_wbs_adr   = adr_q;
   assign io_wbs_datwr = dat_q;
   assign io_wbs_we    = we_q;
   assign io_wbs_cyc   = cyc_q;
   assign io_wbs_stb   = cyc_q;
   assign busy_o       = busy_q;
   assign tx_valid     = (state_q == ST_RESP) && (resp_cnt_q != resp_len_q);

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      we_d       = we_q;
      cyc_d      = cyc_q;
      byte_cnt_d = byte_cnt_q;
      resp_buf_d = resp_buf_q;
      resp_cnt_d = resp_cnt_q;
      resp_len_d = resp_len_q;
`ifdef UART_WB_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               byte_cnt_d = '0;
               if (rx_data == CMD_WRITE) begin
                  we_d    = 1'b1;
                  state_d = ST_ADDR;
               end else if (rx_data == CMD_READ) begin
                  we_d    = 1'b0;
                  state_d = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (rx_err) begin
               state_d = ST_IDLE;
            end else if (rx_valid) begin
               adr_d      = {adr_q[BUSW-9:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (we_q) begin
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_WB;
                     cyc_d   = 1'b1;
`ifdef UART_WB_TIMEOUT_EN
                     tmo_cnt_d = '0;
`endif
                  end
               end
            end
         end
         ST_DATA: begin
            if (rx_err) begin
               state_d = ST_IDLE;
            end else if (rx_valid) begin
               dat_d      = {dat_q[BUSW-9:0], rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = ST_WB;
                  cyc_d   = 1'b1;
`ifdef UART_WB_TIMEOUT_EN
                  tmo_cnt_d = '0;
`endif
               end
            end
         end
         ST_WB: begin
            if (io_wbs_ack) begin
               cyc_d      = 1'b0;
               state_d    = ST_RESP;
               resp_cnt_d = '0;
               if (we_q) begin
                  resp_buf_d = {RSP_ACK, {(BUSW-8){1'b0}}};
                  resp_len_d = 3'd1;
               end else begin
                  resp_buf_d = io_wbs_datrd;
                  resp_len_d = 3'd4;
               end
            end
`ifdef UART_WB_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               cyc_d      = 1'b0;
               state_d    = ST_RESP;
               resp_cnt_d = '0;
               resp_buf_d = {RSP_TIMEOUT, {(BUSW-8){1'b0}}};
               resp_len_d = 3'd1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
`endif
         end
         // Stay here until the final stop bit has left the transmitter.
         ST_RESP: begin
            if (resp_cnt_q != resp_len_q) begin
               if (tx_ready) begin
                  resp_buf_d = resp_buf_q << 8;
                  resp_cnt_d = resp_cnt_q + 3'd1;
               end
            end else if (tx_idle) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
      if (!io_wbs_rst_n) begin
         state_q    <= ST_IDLE;
         adr_q      <= '0;
         dat_q      <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         byte_cnt_q <= '0;
         resp_buf_q <= '0;
         resp_cnt_q <= '0;
         resp_len_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         we_q       <= we_d;
         cyc_q      <= cyc_d;
         byte_cnt_q <= byte_cnt_d;
         resp_buf_q <= resp_buf_d;
         resp_cnt_q <= resp_cnt_d;
         resp_len_q <= resp_len_d;
         busy_q     <= busy_d;
      end
   end

`ifdef UART_WB_TIMEOUT_EN
   always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
      if (!io_wbs_rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_wb_master.sv
// Scoreboard bench for uart_wb_master: directed UART frames, a Wishbone slave model and a UART TX monitor.
// The timeout scenario runs only when UART_WB_TIMEOUT_EN is defined.
module tb_uart_wb_master;

   localparam int CLKS = 8;
   localparam int TMO  = 16;

   typedef logic [7:0] byteQ_t[$];
   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } wbExp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxLine = 1'b1;
   logic        tx;
   logic [31:0] adr, datwr;
   logic [31:0] datrd;
   logic        we, stb, cyc, busy;
   logic        ack;

   wbExp_t     expWb[$];
   logic [7:0] expTx[$];
   int         checks = 0;
   int         errors = 0;

   int          ackDelay      = 0;
   logic        ackEnable     = 1'b1;
   logic [31:0] readData      = 32'h0;
   logic        expectTimeout = 1'b0;

   always #5 clk = ~clk;

   uart_wb_master #(
      .BUSW          (32),
      .CLKS_PER_BIT  (CLKS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .io_wbs_clk  (clk),
      .io_wbs_rst_n(rst_n),
      .uart_rx_i   (rxLine),
      .uart_tx_o   (tx),
      .io_wbs_adr  (adr),
      .io_wbs_datwr(datwr),
      .io_wbs_datrd(datrd),
      .io_wbs_we   (we),
      .io_wbs_stb  (stb),
      .io_wbs_cyc  (cyc),
      .io_wbs_ack  (ack),
      .busy_o      (busy)
   );

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic uartSendByte(input logic [7:0] b, input logic stopBit);
      rxLine = 1'b0;
      repeat (CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxLine = b[i];
         repeat (CLKS) @(negedge clk);
      end
      rxLine = stopBit;
      repeat (CLKS) @(negedge clk);
      rxLine = 1'b1;
   endtask

   task automatic applyStimulus(input byteQ_t frame);
      foreach (frame[i]) uartSendByte(frame[i], 1'b1);
   endtask

   task automatic pushWb(input logic w, input logic [31:0] a, input logic [31:0] d);
      wbExp_t e;
      e.we  = w;
      e.adr = a;
      e.dat = d;
      expWb.push_back(e);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while ((busy || expTx.size() != 0 || expWb.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_idle"}, {31'd0, busy}, 32'd0);
      checkOutput({name, "_drained"}, expTx.size() + expWb.size(), 32'd0);
      repeat (2 * CLKS) @(negedge clk);
   endtask

   // Wishbone slave model plus bus-side scoreboard
   initial begin
      logic        busActive;
      logic        holdErr;
      int          waitCnt;
      logic [31:0] holdAdr, holdDat;
      logic        holdWe;
      wbExp_t      e;
      busActive = 1'b0;
      holdErr   = 1'b0;
      waitCnt   = 0;
      holdAdr   = '0;
      holdDat   = '0;
      holdWe    = 1'b0;
      ack       = 1'b0;
      datrd     = '0;
      forever begin
         @(negedge clk);
         if (ack) begin
            ack = 1'b0;
            checkOutput("wb_release_after_ack", {30'd0, cyc, stb}, 32'd0);
            checkOutput("wb_hold_stable", {31'd0, holdErr}, 32'd0);
            busActive = 1'b0;
         end else if (rst_n && cyc && stb) begin
            if (!busActive) begin
               busActive = 1'b1;
               waitCnt   = 0;
               holdErr   = 1'b0;
               holdAdr   = adr;
               holdDat   = datwr;
               holdWe    = we;
               if (expWb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL wb_unexpected_cycle: got adr 0x%0h we %0b, required no bus cycle", adr, we);
               end else begin
                  e = expWb.pop_front();
                  checkOutput("wb_we", {31'd0, we}, {31'd0, e.we});
                  checkOutput("wb_adr", adr, e.adr);
                  if (e.we) checkOutput("wb_datwr", datwr, e.dat);
               end
            end else if (adr !== holdAdr || datwr !== holdDat || we !== holdWe) begin
               holdErr = 1'b1;
            end
            if (ackEnable && waitCnt == ackDelay) begin
               ack   = 1'b1;
               datrd = readData;
            end
            waitCnt++;
         end else begin
            if (busActive && expectTimeout) begin
               checkOutput("timeout_cycles", waitCnt, TMO);
               expectTimeout = 1'b0;
            end
            busActive = 1'b0;
         end
      end
   end

   // UART TX monitor: decodes bytes at bit centres and pops the expected queue
   initial begin
      logic [7:0] b;
      logic       startBit, stopBit;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            repeat (CLKS / 2) @(negedge clk);
            startBit = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CLKS) @(negedge clk);
               b[i] = tx;
            end
            repeat (CLKS) @(negedge clk);
            stopBit = tx;
            if (expTx.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL tx_unexpected: got byte 0x%0h, required no response", b);
            end else begin
               e = expTx.pop_front();
               checkOutput("tx_byte", {24'd0, b}, {24'd0, e});
               checkOutput("tx_framing", {30'd0, startBit, stopBit}, 32'd1);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete within cycle budget");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      byteQ_t frame;
      int     n;

      $display("[TB] reset");
      repeat (5) @(negedge clk);
      checkOutput("reset_tx", {31'd0, tx}, 32'd1);
      checkOutput("reset_cyc_stb_we", {29'd0, cyc, stb, we}, 32'd0);
      checkOutput("reset_adr", adr, 32'd0);
      checkOutput("reset_datwr", datwr, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (4 * CLKS) @(negedge clk);

      $display("[TB] write frame");
      ackDelay = 0;
      pushWb(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
      expTx.push_back(8'h4B);
      frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      applyStimulus(frame);
      waitIdle("write");

      $display("[TB] read frame with delayed ack");
      ackDelay = 3;
      readData = 32'h1234_5678;
      pushWb(1'b0, 32'h0000_0008, 32'h0);
      expTx.push_back(8'h12);
      expTx.push_back(8'h34);
      expTx.push_back(8'h56);
      expTx.push_back(8'h78);
      frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
      applyStimulus(frame);
      waitIdle("read");

      $display("[TB] unknown command then read");
      frame = '{8'hAA};
      applyStimulus(frame);
      checkOutput("unknown_cmd_idle", {31'd0, busy}, 32'd0);
      ackDelay = 1;
      readData = 32'hCAFE_F00D;
      pushWb(1'b0, 32'h0000_0010, 32'h0);
      expTx.push_back(8'hCA);
      expTx.push_back(8'hFE);
      expTx.push_back(8'hF0);
      expTx.push_back(8'h0D);
      frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h10};
      applyStimulus(frame);
      waitIdle("unknown_then_read");

      $display("[TB] framing error mid-address");
      frame = '{8'h57, 8'h00};
      applyStimulus(frame);
      checkOutput("framing_busy_before", {31'd0, busy}, 32'd1);
      uartSendByte(8'h00, 1'b0);
      repeat (2 * CLKS) @(negedge clk);
      checkOutput("framing_back_to_idle", {31'd0, busy}, 32'd0);
      repeat (4 * CLKS) @(negedge clk);
      ackDelay = 0;
      pushWb(1'b1, 32'h0000_000C, 32'h0102_0304);
      expTx.push_back(8'h4B);
      frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(frame);
      waitIdle("framing_recovery");

`ifdef UART_WB_TIMEOUT_EN
      $display("[TB] ack timeout");
      ackEnable     = 1'b0;
      expectTimeout = 1'b1;
      pushWb(1'b0, 32'h0000_0020, 32'h0);
      expTx.push_back(8'h45);
      frame = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
      applyStimulus(frame);
      waitIdle("timeout");
      checkOutput("timeout_observed", {31'd0, expectTimeout}, 32'd0);
      ackEnable = 1'b1;
`endif

      $display("[TB] reset during bus cycle");
      ackEnable = 1'b0;
      pushWb(1'b1, 32'h0000_0100, 32'h1122_3344);
      frame = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(frame);
      n = 0;
      while (!cyc && n < 4 * CLKS) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reset_test_cyc_up", {31'd0, cyc}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midcycle_reset_cyc_stb", {30'd0, cyc, stb}, 32'd0);
      checkOutput("midcycle_reset_tx", {31'd0, tx}, 32'd1);
      checkOutput("midcycle_reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      ackEnable = 1'b1;
      repeat (30 * CLKS) @(negedge clk);
      checkOutput("after_reset_idle", {31'd0, busy}, 32'd0);
      checkOutput("after_reset_queues", expTx.size() + expWb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
